// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter:
//   - arb_state_t : arbiter state encoding (idle / grant)
//   - DEFAULT_DATA_W : default data width, matching the FIFO data_in
//   - rr_next()  : wrap-around "next index" helper for round-robin pointers
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_W = 32'd8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 32'sd1 >= n) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin search. Finds the first set bit of mask,
//   scanning upward from start and wrapping past N-1 back to 0, so start
//   itself has the highest priority and start-1 the lowest.
// Ports:
//   mask  in  N   candidate request mask
//   start in  IW  index with highest priority
//   found out 1   any bit of mask set
//   idx   out IW  winning index (0 when nothing found)
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand_s;

    // Scan from the lowest priority to the highest so the last match written
    // is the winner.
    always_comb begin
        found  = |mask;
        idx    = '0;
        cand_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s = IW'((int'(start) + k) % N);
            idx    = mask[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ
//   valid/ready requesters. The owner keeps the grant for up to MAX_BURST
//   beats, or until it drops valid. The FIFO is never written while full.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   req_valid    in   NUM_REQ         per-requester valid
//   req_data     in   NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ         per-requester accept (one-hot or zero)
//   fifo_full    in   FIFO full flag
//   fifo_wr      out  FIFO write strobe (same cycle as the beat)
//   fifo_data_in out  DATA_W          FIFO write data (owner's slice while granted)
//   grant_id     out  current owner index (registered)
//   busy         out  high while a grant is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    arb_state_t    state_r, state_nxt_s;
    logic [IW-1:0] owner_r, owner_nxt_s;
    logic [IW-1:0] last_r, last_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;

    logic          in_grant_s;
    logic          owner_valid_s;
    logic          beat_s;
    logic          rel_s;
    logic [IW-1:0] pick_start_s;
    logic          pick_found_s;
    logic [IW-1:0] pick_idx_s;
    logic [DATA_W-1:0] slice_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice_s[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign in_grant_s    = (state_r == ARB_GRANT);
    assign owner_valid_s = req_valid[owner_r];
    assign beat_s        = in_grant_s && owner_valid_s && !fifo_full;
    // Release on the last beat of a burst, or as soon as the owner withdraws
    // valid. A full FIFO alone never releases the grant.
    assign rel_s         = in_grant_s && ((beat_s && (cnt_r == LAST_BEAT)) || !owner_valid_s);

    // Search start: after the owner on a release, after the last owner from idle.
    always_comb begin
        if (in_grant_s) begin
            pick_start_s = IW'(rr_next(int'(owner_r), NUM_REQ));
        end else begin
            pick_start_s = IW'(rr_next(int'(last_r), NUM_REQ));
        end
    end

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .mask  (req_valid),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state logic: arbitration, burst counting and release/handover.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ARB_GRANT;
                    owner_nxt_s = pick_idx_s;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (rel_s) begin
                    // Same-cycle re-arbitration gives zero-bubble handover;
                    // a sole requester wraps around and wins again.
                    last_nxt_s = owner_r;
                    cnt_nxt_s  = '0;
                    if (pick_found_s) begin
                        state_nxt_s = ARB_GRANT;
                        owner_nxt_s = pick_idx_s;
                    end else begin
                        state_nxt_s = ARB_IDLE;
                    end
                end else if (beat_s) begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                owner_nxt_s = '0;
                last_nxt_s  = LAST_IDX;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State register; reset leaves last at the top index so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            owner_r <= '0;
            last_r  <= LAST_IDX;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Ready goes only to the owner, and only while the FIFO can take data.
    always_comb begin
        req_ready          = '0;
        req_ready[owner_r] = in_grant_s && !fifo_full;
    end

    assign fifo_wr      = |(req_valid & req_ready);
    assign fifo_data_in = in_grant_s ? slice_s[owner_r] : '0;
    assign grant_id     = owner_r;
    assign busy         = in_grant_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Table-driven bench: each record is one clock cycle of inputs and the
//   outputs expected in that cycle. Inputs change 1ns after the rising edge,
//   outputs are sampled on the falling edge. A hand-written sequence covers
//   an asynchronous reset pulse in the middle of a burst.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       full;
        logic [3:0] ready;
        logic       wr;
        logic [7:0] data;
        logic [1:0] gid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Requester i always presents 8'h11*(i+1).
    function automatic logic [7:0] sl(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    function automatic void add(input logic r, input logic [3:0] v, input logic f,
                                input logic [3:0] rdy, input logic w, input logic [7:0] d,
                                input logic [1:0] g, input logic b);
        vec_t x;
        x.rst = r; x.valid = v; x.full = f; x.ready = rdy;
        x.wr = w; x.data = d; x.gid = g; x.busy = b;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset with everyone valid, then continuous traffic: 4 beats each
        // in order 0,1,2,3,0 with no gap at handover.
        add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            int o;
            o = ((c - 1) / 4) % 4;
            add(1'b0, 4'b1111, 1'b0, 4'(1 << o), 1'b1, sl(o), 2'(o), 1'b1);
        end

        // req2 alone for 10 beats (4,4,2), then drop: one dead cycle, then idle.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
        end
        add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);

        // req1: two beats, FIFO full for 3 cycles, then beats 3-4 and a re-grant.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
        end
        for (int c = 3; c <= 5; c++) begin
            add(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1);
        end
        for (int c = 6; c <= 8; c++) begin
            add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
        end

        // req1 drops after one beat while req3 waits: one dead cycle, then req3.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            req_valid = vecs[i].valid;
            fifo_full = vecs[i].full;
            @(negedge clk);
            chk("req_ready", i, 32'(req_ready), 32'(vecs[i].ready));
            chk("fifo_wr",   i, 32'(fifo_wr),   32'(vecs[i].wr));
            chk("grant_id",  i, 32'(grant_id),  32'(vecs[i].gid));
            chk("busy",      i, 32'(busy),      32'(vecs[i].busy));
            if (vecs[i].wr || vecs[i].rst) begin
                chk("fifo_data_in", i, 32'(fifo_data_in), 32'(vecs[i].data));
            end
        end

        // Async reset pulse in the middle of req3's burst (beat 3).
        @(posedge clk);
        #1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("rst_pre_wr",  100, 32'(fifo_wr),   32'd1);
        chk("rst_pre_gid", 100, 32'(grant_id),  32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_wr",    101, 32'(fifo_wr),      32'd0);
        chk("rst_async_ready", 101, 32'(req_ready),    32'd0);
        chk("rst_async_gid",   101, 32'(grant_id),     32'd0);
        chk("rst_async_busy",  101, 32'(busy),         32'd0);
        chk("rst_async_data",  101, 32'(fifo_data_in), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_wr",   102, 32'(fifo_wr), 32'd0);
        chk("rst_hold_busy", 102, 32'(busy),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_arb_busy",  103, 32'(busy),      32'd0);
        chk("rst_arb_ready", 103, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rst_next_ready", 104, 32'(req_ready),    32'b0010);
        chk("rst_next_wr",    104, 32'(fifo_wr),      32'd1);
        chk("rst_next_gid",   104, 32'(grant_id),     32'd1);
        chk("rst_next_data",  104, 32'(fifo_data_in), 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single 8-bit FIFO write port among several requesters. Each requester presents a valid/ready stream, and the winner keeps the grant for a bounded burst. The arbiter drives the FIFO's `wr`/`data_in` and honours `full`, so the FIFO never sees a write while full. It sits between the traffic sources and the FIFO write side, in the same `clk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 8: data width; matches the FIFO `data_in`.
- `MAX_BURST`, default 4: maximum consecutive beats per grant (≥1).

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_W  packed data; requester i uses `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_data_in`  out  DATA_W  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  current owner index; registered.
- `busy`  out  1  high in GRANT state.

## Operation
- Beat: `req_valid[i] && req_ready[i]` in a cycle.
- Requester rule: hold data stable while valid && !ready. Dropping valid without a beat is legal and releases the grant.
- `req_ready[i] = (state==GRANT) && (owner==i) && !fifo_full`.
- `fifo_wr = |(req_valid & req_ready)`; `fifo_data_in` = owner's data slice.
- Both are combinational, so the write lands in the same cycle as the beat.
- State machine, states `ARB_IDLE` and `ARB_GRANT`:
  - IDLE: if any `req_valid`, pick the first valid index searching upward from `last+1` (wrapping). Register `owner`, `burst_cnt=0`, go to GRANT. Otherwise stay.
  - GRANT, each beat: `burst_cnt++`.
  - GRANT release condition: (beat && `burst_cnt==MAX_BURST-1`) || !`req_valid[owner]`.
  - On release: `last<=owner`, then re-arbitrate in the same cycle from `owner+1` over the current `req_valid`. If there is a winner, enter GRANT with the new owner and `burst_cnt=0`; otherwise go to IDLE.
  - A sole requester that hits the burst limit is re-granted immediately after the RR search wraps.
- `fifo_full` in GRANT: no beat, and `owner` and `burst_cnt` hold. There is no timeout and no release on full alone.
- `burst_cnt` width: $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1.

## Timing
- Reset (async assert, immediate):
  - state=IDLE, owner=0, `grant_id`=0, `burst_cnt`=0.
  - `last`=NUM_REQ-1, so requester 0 has first priority.
  - `busy`=0, `req_ready`=0, `fifo_wr`=0, `fifo_data_in`=0.
- Reset mid-burst: the grant is lost and no write occurs while `rst` is high. After deassertion, arbitration restarts from requester 0.
- Latency:
  - IDLE→first beat: 1 cycle (the arbitration cycle).
  - Back-to-back handover on burst limit: 0 bubble cycles.
  - Handover on valid drop: 1 dead cycle (the cycle that detected the drop).
- Throughput: 1 beat/cycle while the owner is valid and `!fifo_full`.
- `grant_id`/`busy` update on the clock edge after the arbitration decision.
- Simultaneous requests: RR order from `last+1`. No requester waits more than (NUM_REQ-1)·MAX_BURST beats plus handover cycles.

## Structure
- Package `fifo_arb_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_GRANT}; shared `DATA_W` default constant.
- Sub-module `rr_picker`: combinational. Inputs are the request mask and start pointer; outputs are `found` and `idx`. It is used for both the IDLE and release arbitration paths.
- All registers live in a single always_ff block with async `rst`.

## Test plan
- Reset with all `req_valid`=1 → `req_ready`=0, `fifo_wr`=0, `grant_id`=0. After release, the first beat is from req0 on cycle 2.
- req0..3 continuously valid, `fifo_full`=0, MAX_BURST=4 → 4 beats each in order 0,1,2,3,0, with no gaps at handover. `fifo_data_in` matches each slice.
- req2 alone, valid for 10 beats → bursts of 4,4,2 all to req2 with 0 bubbles. The drop after 10 beats → 1 dead cycle, then IDLE.
- `fifo_full`=1 for 3 cycles mid-burst (after beat 2 of req1) → `fifo_wr`=0 and `req_ready`=0 for 3 cycles, `grant_id` stays 1. Beats 3–4 then complete.
- req1 drops valid after 1 beat while req3 is valid → next owner is req3 after 1 dead cycle. Only req1's `req_ready` was ever asserted before that.
- Async `rst` pulsed mid-burst of req3 → outputs go to 0 immediately, with no write during reset. The next grant goes to the lowest valid index.
